// File: rtl/mips_div_unit.sv
// Multi-cycle MIPS DIV/DIVU unit: restoring division, one quotient bit per
// CALC cycle, with sign fix-up and the divide-by-zero result applied on FIN.
module mips_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             sa, sb, sop, dz;

  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0]   diff;
  logic             accept;

  // Operand magnitudes; the two's-complement negation also maps the most
  // negative value to itself, which is the right unsigned magnitude.
  assign a_mag  = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_mag  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign accept = start && !cancel;

  // Trial subtract on the shifted partial remainder; WIDTH+1 bits because
  // the shifted value can reach 2^(WIDTH+1)-1.
  assign diff = {rem, quo[WIDTH-1]} - {1'b0, dvs};

  // With a zero divisor the loop leaves rem = |dividend|, so the remainder
  // sign fix-up alone restores the dividend; only the quotient is forced.
  assign q_fix = dz ? '1 : ((sop && (sa ^ sb)) ? -quo : quo);
  assign r_fix = (sop && sa) ? -rem : rem;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: cancel beats start and aborts CALC/FIN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cancel) state_nxt = IDLE;
               else if (cnt == CW'(WIDTH - 1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: operand latch, restoring step, result write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      sop         <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          cnt <= '0;
          rem <= '0;
          quo <= a_mag;
          dvs <= b_mag;
          sa  <= dividend[WIDTH-1];
          sb  <= divisor[WIDTH-1];
          sop <= signed_op;
          dz  <= (divisor == '0);
        end
        CALC: if (!cancel) begin
          cnt <= cnt + CW'(1);
          if (!diff[WIDTH]) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
        end
        FIN: if (!cancel) begin
          quotient    <= q_fix;
          remainder   <= r_fix;
          div_by_zero <= dz;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div_unit.sv
// Directed bench for mips_div_unit: hand-computed DIV/DIVU results, latency,
// busy width, ignored start, cancel and mid-operation reset.
module tb_mips_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        cancel = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int nchk = 0;
  int nerr = 0;
  int lat, bcnt, n, dcnt;

  mips_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .cancel(cancel),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one operation; returns edges from the start edge to done and the
  // number of sampled cycles with busy high.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output int l, output int bc);
    @(negedge clk);
    start = 1'b1; signed_op = s; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    l = 0;
    bc = busy ? 1 : 0;
    while (!done && l < 100) begin
      @(posedge clk); #1;
      l++;
      if (!done && busy) bc++;
    end
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (!done && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", quotient, 32'h0);
    chk("rst_r", remainder, 32'h0);
    chk("rst_dz", {31'b0, div_by_zero}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    @(negedge clk) rst = 1'b0;

    // DIVU 100/7
    do_op(1'b0, 32'd100, 32'd7, lat, bcnt);
    chk("divu100_7_lat", 32'(lat), 32'd33);
    chk("divu100_7_busy", 32'(bcnt), 32'd33);
    chk("divu100_7_q", quotient, 32'd14);
    chk("divu100_7_r", remainder, 32'd2);
    chk("divu100_7_dz", {31'b0, div_by_zero}, 32'h0);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'b0, done}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_q", quotient, 32'd14);

    // DIV -7/2 and DIVU of the same bits
    do_op(1'b1, 32'hFFFFFFF9, 32'd2, lat, bcnt);
    chk("div_m7_2_q", quotient, 32'hFFFFFFFD);
    chk("div_m7_2_r", remainder, 32'hFFFFFFFF);
    do_op(1'b0, 32'hFFFFFFF9, 32'd2, lat, bcnt);
    chk("divu_m7_2_q", quotient, 32'h7FFFFFFC);
    chk("divu_m7_2_r", remainder, 32'd1);

    // Overflow case
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
    chk("ovf_q", quotient, 32'h80000000);
    chk("ovf_r", remainder, 32'h0);
    chk("ovf_dz", {31'b0, div_by_zero}, 32'h0);

    // Divide by zero, then a normal op clears the flag
    do_op(1'b0, 32'd5, 32'd0, lat, bcnt);
    chk("dz_lat", 32'(lat), 32'd33);
    chk("dz_q", quotient, 32'hFFFFFFFF);
    chk("dz_r", remainder, 32'd5);
    chk("dz_flag", {31'b0, div_by_zero}, 32'h1);
    do_op(1'b0, 32'd9, 32'd3, lat, bcnt);
    chk("after_dz_q", quotient, 32'd3);
    chk("after_dz_flag", {31'b0, div_by_zero}, 32'h0);
    do_op(1'b1, 32'hFFFFFFF9, 32'd0, lat, bcnt);
    chk("sdz_q", quotient, 32'hFFFFFFFF);
    chk("sdz_r", remainder, 32'hFFFFFFF9);
    chk("sdz_flag", {31'b0, div_by_zero}, 32'h1);

    // Start while busy is ignored
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 32'd8; divisor = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    chk("ign_lat", 32'(n + 10), 32'd33);
    chk("ign_q", quotient, 32'd10);
    chk("ign_r", remainder, 32'd0);

    // Cancel at cycle 10
    @(negedge clk);
    start = 1'b1; dividend = 32'd8; divisor = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel_busy", {31'b0, busy}, 32'h0);
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("cancel_no_done", 32'(dcnt), 32'd0);
    chk("cancel_q", quotient, 32'd10);
    chk("cancel_r", remainder, 32'd0);
    chk("cancel_dz", {31'b0, div_by_zero}, 32'h0);

    // Reset at cycle 20, with nonzero prior outputs
    do_op(1'b0, 32'd7, 32'd0, lat, bcnt);
    chk("pre_rst_dz", {31'b0, div_by_zero}, 32'h1);
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_q", quotient, 32'h0);
    chk("mrst_r", remainder, 32'h0);
    chk("mrst_dz", {31'b0, div_by_zero}, 32'h0);
    chk("mrst_busy", {31'b0, busy}, 32'h0);
    chk("mrst_done", {31'b0, done}, 32'h0);
    rst = 1'b0;
    do_op(1'b0, 32'd9, 32'd3, lat, bcnt);
    chk("post_rst_lat", 32'(lat), 32'd33);
    chk("post_rst_q", quotient, 32'd3);

    // Back-to-back: start accepted in the done cycle
    @(negedge clk);
    start = 1'b1; dividend = 32'd21; divisor = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    chk("b2b_q", quotient, 32'd5);
    chk("b2b_r", remainder, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/mips_div_unit.md
MIPS_DIV_UNIT -- requirements
Module: mips_div_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width in bits; iteration count equals WIDTH.
REQ-002 SHALL use one clock and a reset that is synchronous and active-high.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-006 SHALL have port signed_op  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-007 SHALL have port dividend  input  WIDTH  numerator; sampled with start.
REQ-008 SHALL have port divisor  input  WIDTH  denominator; sampled with start.
REQ-009 SHALL have port cancel  input  1  pipeline flush; aborts an operation in progress.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a result is written.
REQ-012 SHALL have port quotient  output  WIDTH  registered quotient (LO).
REQ-013 SHALL have port remainder  output  WIDTH  registered remainder (HI).
REQ-014 SHALL have port div_by_zero  output  1  registered flag for the last completed operation.

Function
REQ-015 SHALL implement states IDLE, CALC, FIN; IDLE->CALC on start; CALC->FIN after WIDTH steps; FIN->IDLE unconditionally.
REQ-016 SHALL, at the start edge, latch the operand magnitudes (absolute values when signed_op=1), both sign bits, signed_op, and a divisor==0 flag, and clear the step counter and partial remainder.
REQ-017 SHALL perform one restoring step per CALC cycle: shift {rem,quo} left by one; trial subtract |divisor| from rem in a WIDTH+1-bit result; keep the difference and set quotient LSB=1 if it is non-negative, else restore and set LSB=0.
REQ-018 SHALL, on the FIN edge, write quotient and remainder, set done=1 for exactly the following cycle, and update div_by_zero.
REQ-019 SHALL, for signed_op=1, negate the quotient when the operand signs differ and give the remainder the sign of the dividend.
REQ-020 SHALL produce quotient=0x80000000 and remainder=0 for signed 0x80000000/0xFFFFFFFF, with no trap and no flag.
REQ-021 SHALL, for divisor==0, output quotient = all ones and remainder = dividend as sampled, set div_by_zero=1, and keep the normal latency.
REQ-022 SHALL give latency: start sampled at edge N; CALC edges N+1..N+WIDTH; result and done visible after edge N+WIDTH+1 (33 cycles for WIDTH=32).
REQ-023 SHALL ignore start while busy=1; operands presented then are not sampled.
REQ-024 SHALL, when cancel=1 in CALC or FIN, go to IDLE at that edge with no done pulse and with quotient, remainder and div_by_zero unchanged.
REQ-025 SHALL give cancel priority over start when both are asserted in the same cycle; cancel in IDLE has no effect.
REQ-026 SHALL hold quotient, remainder and div_by_zero stable between done pulses.
REQ-027 SHALL accept start in the cycle in which done=1 (state is IDLE), so operations can run back-to-back.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, force state to IDLE and set busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear the counter.
REQ-029 SHALL give rst priority over cancel and start, including when reset occurs mid-operation; no done pulse follows.

Verification
REQ-030 SHALL cover DIVU 100/7 -> quotient=14, remainder=2, div_by_zero=0, done pulses exactly 33 cycles after the start edge, busy high for 33 cycles.
REQ-031 SHALL cover DIV 0xFFFFFFF9 (-7)/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; DIVU with the same operands -> quotient=0x7FFFFFFC, remainder=1.
REQ-032 SHALL cover DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-033 SHALL cover DIVU 5/0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, done at cycle 33; a following 9/3 clears div_by_zero and gives quotient=3.
REQ-034 SHALL cover start 50/5, then at cycle 10 start 8/2 -> the second start is ignored and the result is quotient=10; repeat with cancel at cycle 10 -> no done, outputs keep their prior values, busy=0 next cycle.
REQ-035 SHALL cover rst asserted at cycle 20 of an operation -> all outputs 0 next cycle and no done pulse; a new start immediately after rst runs normally.
